// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end.
//   - FSM state encoding
//   - 2-bit command codes carried in frame bits [9:8]
//   - default frame / read-data widths
//   - helper that classifies the first frame bit as read or write
package spi_pkg;

    localparam int DEF_FRAME_W = 10;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Frame bit 9 alone separates reads from writes; bit 8 is left to the memory.
    function automatic logic is_read_cmd(input logic bit9);
        return bit9 == CMD_RD_ADDR[1];
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// MSB-first parallel-load shifter driving the registered MISO line.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_clear    : abandon any transfer, MISO to 0, drop done
//   i_load     : capture i_data, present its MSB on o_miso next edge
//   i_data     : parallel read data
//   o_miso     : registered serial output (0 when idle)
//   o_busy     : a transfer is in progress
//   o_done     : sticky, all bits sent (until i_clear)
//   o_last     : this edge ends the transfer (MISO returns to 0)
module spi_tx_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_miso,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_last
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_miso;
    logic              r_busy;
    logic              r_done;

    // r_cnt counts bits already presented on MISO; after DATA_W of them the
    // next edge returns the line to 0.
    assign o_last = r_busy && (r_cnt == CNT_W'(DATA_W));

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_load) begin
            r_shift <= {i_data[DATA_W-2:0], 1'b0};
            r_miso  <= i_data[DATA_W-1];
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
        end else if (o_last) begin
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
        end else if (r_busy) begin
            r_miso  <= r_shift[DATA_W-1];
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_miso = r_miso;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave serial front end: collects MOSI frames (dummy bit + 10 bits,
// MSB first) into words for the data memory and shifts memory read data
// back out on MISO. SPI bit clock is clk.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   SS_n       : slave select, active low, frames a transaction
//   MOSI       : serial data in, MSB first
//   MISO       : registered serial read data out, MSB first
//   rx_data    : last complete received word ([9:8] command, [7:0] payload)
//   rx_valid   : one-cycle strobe for a new rx_data word
//   tx_data    : memory read data
//   tx_valid   : memory read data valid
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [FRAME_W-2:0] r_rx_shift;
    logic [FRAME_W-1:0] r_rx_data;
    logic               r_rx_valid;
    logic               r_rd_addr_seen;
    logic [CNT_W-1:0]   r_bit_cnt;

    logic w_abort;
    logic w_rx_shift;
    logic w_rx_complete;
    logic w_tx_load;
    logic w_tx_miso;
    logic w_tx_busy;
    logic w_tx_done;
    logic w_tx_last;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_abort       = 1'b0;
        w_rx_shift    = 1'b0;
        w_rx_complete = 1'b0;
        w_tx_load     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The MOSI bit on this edge is the dummy bit and is dropped.
                if (!SS_n) w_state_next = ST_CHK_CMD;
            end
            ST_CHK_CMD: begin
                if (SS_n) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_rx_shift = 1'b1;
                    if (!is_read_cmd(MOSI))  w_state_next = ST_WRITE;
                    else if (r_rd_addr_seen) w_state_next = ST_READ_DATA;
                    else                     w_state_next = ST_READ_ADD;
                end
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                if (SS_n) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end else if (r_bit_cnt < CNT_W'(FRAME_W)) begin
                    w_rx_shift    = 1'b1;
                    w_rx_complete = (r_bit_cnt == CNT_W'(FRAME_W - 1));
                end else if (r_state == ST_READ_DATA && !w_tx_busy && !w_tx_done
                             && tx_valid) begin
                    // tx_valid is only meaningful once the memory has decoded a
                    // read-data word, i.e. here.
                    w_tx_load = 1'b1;
                end
                // Otherwise the frame is finished: wait for SS_n to rise.
            end
            default: begin
                w_state_next = ST_IDLE;
                w_abort      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_shift     <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_bit_cnt      <= '0;
        end else begin
            r_rx_valid <= w_rx_complete;
            if (w_abort) begin
                r_bit_cnt <= '0;
            end else if (w_rx_shift) begin
                r_rx_shift <= {r_rx_shift[FRAME_W-3:0], MOSI};
                r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
            end
            if (w_rx_complete) begin
                r_rx_data <= {r_rx_shift, MOSI};
                if (r_state == ST_READ_ADD) r_rd_addr_seen <= 1'b1;
            end
            if (w_tx_last && !w_abort) r_rd_addr_seen <= 1'b0;
        end
    end

    spi_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_abort),
        .i_load  (w_tx_load),
        .i_data  (tx_data),
        .o_miso  (w_tx_miso),
        .o_busy  (w_tx_busy),
        .o_done  (w_tx_done),
        .o_last  (w_tx_last)
    );

    assign MISO     = w_tx_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: expected rx words are queued when a
// frame is driven and popped whenever rx_valid is seen; expected MISO bits
// are queued when a read-data transfer is expected.
module tb_spi_slave_ctrl;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] rx_exp_q[$];
    logic       miso_exp_q[$];

    always #5 clk = ~clk;

    spi_slave_ctrl #(
        .FRAME_W (10),
        .DATA_W  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // rx scoreboard: every rx_valid pulse must match the oldest queued frame.
    always @(posedge clk) begin
        logic [9:0] exp_word;
        #1;
        if (rx_valid === 1'b1) begin
            if (rx_exp_q.size() == 0) begin
                check_eq("rx_unexpected", {31'b0, rx_valid}, 32'd0);
            end else begin
                exp_word = rx_exp_q.pop_front();
                check_eq("rx_data", {22'b0, rx_data}, {22'b0, exp_word});
                $display("[TB] rx word 0x%03h (expected 0x%03h)", rx_data, exp_word);
            end
        end
    end

    // Dummy bit plus the first nbits of f, MSB first. Returns on the negedge
    // after the last sampled bit.
    task automatic send_frame(input logic [9:0] f, input int nbits, input bit expect_rx);
        logic miso_seen;
        miso_seen = 1'b0;
        if (expect_rx) rx_exp_q.push_back(f);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'($urandom_range(0, 1));
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            miso_seen = miso_seen | MISO;
            MOSI = f[9-i];
        end
        @(negedge clk);
        miso_seen = miso_seen | MISO;
        check_eq("miso_quiet_rx", {31'b0, miso_seen}, 32'd0);
        $display("[TB] frame 0x%03h sent (%0d bits)", f, nbits);
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        check_eq("state_idle", 32'(dut.r_state), 32'(ST_IDLE));
        check_eq("miso_idle", {31'b0, MISO}, 32'd0);
    endtask

    // Expects the shifter to be loaded on the next rising edge.
    task automatic read_tx(input logic [7:0] d);
        logic e;
        for (int k = 7; k >= 0; k--) miso_exp_q.push_back(d[k]);
        miso_exp_q.push_back(1'b0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            e = miso_exp_q.pop_front();
            check_eq("miso_bit", {31'b0, MISO}, {31'b0, e});
        end
        $display("[TB] tx byte 0x%02h shifted out", d);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic miso_seen;

        // Reset
        repeat (3) @(negedge clk);
        check_eq("rst_miso", {31'b0, MISO}, 32'd0);
        check_eq("rst_rx_data", {22'b0, rx_data}, 32'd0);
        check_eq("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check_eq("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        check_eq("rst_seen", {31'b0, dut.r_rd_addr_seen}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write address
        send_frame({CMD_WR_ADDR, 8'hA5}, 10, 1'b1);
        check_eq("wa_valid_pulse", {31'b0, rx_valid}, 32'd1);
        @(negedge clk);
        check_eq("wa_valid_one_cycle", {31'b0, rx_valid}, 32'd0);
        check_eq("wa_rx_hold", {22'b0, rx_data}, 32'h0A5);
        miso_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MOSI = 1'($urandom_range(0, 1));
            @(negedge clk);
            miso_seen = miso_seen | MISO | rx_valid;
        end
        check_eq("wa_quiet_after", {31'b0, miso_seen}, 32'd0);
        end_frame();

        // Write data
        send_frame({CMD_WR_DATA, 8'h3C}, 10, 1'b1);
        @(negedge clk);
        check_eq("wd_seen", {31'b0, dut.r_rd_addr_seen}, 32'd0);
        end_frame();

        // Read address then read data
        send_frame({CMD_RD_ADDR, 8'h55}, 10, 1'b1);
        check_eq("ra_state", 32'(dut.r_state), 32'(ST_READ_ADD));
        check_eq("ra_seen", {31'b0, dut.r_rd_addr_seen}, 32'd1);
        end_frame();
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        send_frame({CMD_RD_DATA, 8'hE7}, 10, 1'b1);
        check_eq("rd_state", 32'(dut.r_state), 32'(ST_READ_DATA));
        read_tx(8'hC3);
        check_eq("rd_seen_clr", {31'b0, dut.r_rd_addr_seen}, 32'd0);
        miso_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            miso_seen = miso_seen | MISO;
        end
        check_eq("rd_done_quiet", {31'b0, miso_seen}, 32'd0);
        end_frame();
        tx_valid = 1'b0;

        // Abort after 5 bits, then a full frame
        send_frame({CMD_WR_DATA, 8'h77}, 5, 1'b0);
        end_frame();
        check_eq("abort_rx_hold", {22'b0, rx_data}, 32'h3E7);
        check_eq("abort_seen", {31'b0, dut.r_rd_addr_seen}, 32'd0);
        send_frame({CMD_WR_ADDR, 8'h5A}, 10, 1'b1);
        end_frame();

        // Reset in the middle of a TX
        send_frame({CMD_RD_ADDR, 8'hAA}, 10, 1'b1);
        end_frame();
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        send_frame({CMD_RD_DATA, 8'hFF}, 10, 1'b1);
        for (int k = 7; k >= 4; k--) begin
            @(negedge clk);
            check_eq("rstmid_miso", {31'b0, MISO}, {31'b0, tx_data[k]});
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rstmid_miso0", {31'b0, MISO}, 32'd0);
        check_eq("rstmid_valid", {31'b0, rx_valid}, 32'd0);
        check_eq("rstmid_state", 32'(dut.r_state), 32'(ST_IDLE));
        check_eq("rstmid_seen", {31'b0, dut.r_rd_addr_seen}, 32'd0);
        check_eq("rstmid_rx_data", {22'b0, rx_data}, 32'd0);
        rst_n    = 1'b1;
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        $display("[TB] reset during tx applied");

        // Read data with tx_valid never asserted
        send_frame({CMD_RD_ADDR, 8'h01}, 10, 1'b1);
        end_frame();
        tx_data = 8'hFF;
        send_frame({CMD_RD_DATA, 8'h11}, 10, 1'b1);
        miso_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            miso_seen = miso_seen | MISO;
        end
        check_eq("notx_miso", {31'b0, miso_seen}, 32'd0);
        check_eq("notx_seen", {31'b0, dut.r_rd_addr_seen}, 32'd1);
        end_frame();
        check_eq("notx_seen_idle", {31'b0, dut.r_rd_addr_seen}, 32'd1);

        // Address still pending: next read frame goes straight to read data,
        // with tx_valid arriving late
        send_frame({CMD_RD_DATA, 8'hC0}, 10, 1'b1);
        check_eq("late_state", 32'(dut.r_state), 32'(ST_READ_DATA));
        repeat (3) @(negedge clk);
        check_eq("late_miso_wait", {31'b0, MISO}, 32'd0);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        read_tx(8'h5A);
        check_eq("late_seen_clr", {31'b0, dut.r_rd_addr_seen}, 32'd0);
        end_frame();
        tx_valid = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rxq_empty", 32'(rx_exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
